// File: rtl/multi_master_system_bus_if.sv
// multi_master_system_bus_if
//   Bundles the per-master request side and the shared response side of the
//   multi-master system bus.
//   master modport : drives req / rw_select / address / data_in,
//                    observes enable / data_out / data_valid / grant_id /
//                    busy / done / err.
//   slave modport  : the bus itself (the arbiter + RAM), opposite directions.
//   Per-master fields are packed: master i sits at [i*W +: W].
interface multi_master_system_bus_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 8
);
  localparam int GID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0]        req;
  logic [NUM_MASTERS-1:0]        rw_select;
  logic [NUM_MASTERS*ADDR_W-1:0] address;
  logic [NUM_MASTERS*8-1:0]      data_in;
  logic [NUM_MASTERS-1:0]        enable;
  logic [7:0]                    data_out;
  logic                          data_valid;
  logic [GID_W-1:0]              grant_id;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output req, rw_select, address, data_in,
    input  enable, data_out, data_valid, grant_id, busy, done, err
  );

  modport slave (
    input  req, rw_select, address, data_in,
    output enable, data_out, data_valid, grant_id, busy, done, err
  );
endinterface

// File: rtl/multi_master_system_bus.sv
// multi_master_system_bus
//   N-master shared bus with round-robin arbitration and an integrated
//   byte-wide RAM. Each grant moves one word of WORD_BYTES bytes, one byte
//   per cycle, most significant byte first (byte k of word a lives at RAM
//   byte a*WORD_BYTES + k).
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; aborts any transfer in flight
//   bus    : slave side of multi_master_system_bus_if
//            req/rw_select/address/data_in in, enable (one-hot grant strobe),
//            data_out/data_valid (read byte), grant_id, busy, done (end of
//            accepted request), err (out-of-range word address) out.
module multi_master_system_bus #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 8,
  parameter int WORD_BYTES  = 4,
  parameter int NUM_WORDS   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  multi_master_system_bus_if.slave   bus
);
  localparam int GID_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int RAM_BYTES = NUM_WORDS * WORD_BYTES;
  localparam int RAM_AW    = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
  // Wide enough for (2**ADDR_W - 1) * WORD_BYTES + WORD_BYTES - 1.
  localparam int BIDX_W    = ADDR_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

  state_t              state_reg, state_next;
  logic [GID_W-1:0]    grant_reg;
  logic [GID_W-1:0]    last_grant_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                rw_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [7:0]          data_out_reg;
  logic                data_valid_reg;

  logic [7:0]          ram [RAM_BYTES];

  logic                any_req;
  logic [GID_W-1:0]    winner;
  logic [ADDR_W-1:0]   winner_addr;
  logic                winner_in_range;
  logic                ram_we;
  logic                ram_re;
  logic [RAM_AW-1:0]   ram_idx;
  logic [7:0]          wr_byte;

  // Round-robin: scan from last_grant+1 around to last_grant itself, so the
  // previous winner has the lowest priority next time.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    winner = last_grant_reg;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      idx = (int'(last_grant_reg) + off) % NUM_MASTERS;
      if (!found && bus.req[idx]) begin
        winner = GID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req         = |bus.req;
  assign winner_addr     = bus.address[int'(winner)*ADDR_W +: ADDR_W];
  assign winner_in_range = (int'(winner_addr) < NUM_WORDS);

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = winner_in_range ? XFER : ERR;
      XFER:    if (cnt_reg == LAST_BYTE) state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GID_W'(NUM_MASTERS - 1);
      addr_reg       <= '0;
      rw_reg         <= 1'b0;
      cnt_reg        <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        // Latched even on an out-of-range request so rotation still advances.
        grant_reg      <= winner;
        last_grant_reg <= winner;
        addr_reg       <= winner_addr;
        rw_reg         <= bus.rw_select[winner];
        cnt_reg        <= '0;
      end else if (state_reg == XFER) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // The read byte lands one cycle after its XFER cycle.
      data_valid_reg <= (state_reg == XFER) && !rw_reg;
    end
  end

  // Out-of-range addresses never reach XFER, so only the low bits of the
  // wide byte index can be non-zero here.
  assign ram_idx = RAM_AW'(BIDX_W'(addr_reg) * BIDX_W'(WORD_BYTES) + BIDX_W'(cnt_reg));
  assign ram_we  = (state_reg == XFER) && rw_reg;
  assign ram_re  = (state_reg == XFER) && !rw_reg;
  assign wr_byte = bus.data_in[int'(grant_reg)*8 +: 8];

  // RAM contents survive reset, but a write coinciding with reset is dropped
  // so an aborted transfer stops at the bytes already committed.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram[ram_idx] <= wr_byte;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg <= '0;
    end else if (ram_re) begin
      data_out_reg <= ram[ram_idx];
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_enable
    assign bus.enable[gi] = (state_reg == XFER) && (grant_reg == GID_W'(gi));
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.grant_id   = grant_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.err        = (state_reg == ERR);
endmodule
